// File: rtl/mem_io_ctrl.sv
// Load/store access sequencer: decodes one word request into memory or IO space,
// issues registered strobes to the target and returns a single-cycle response.
module mem_io_ctrl #(
    parameter int unsigned MEM_LAT = 1,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter logic [9:0]  LED_OFF = 10'h060,
    parameter logic [9:0]  SW_OFF  = 10'h070,
    parameter logic [9:0]  SEG_OFF = 10'h080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        led_we,
    output logic        seg_we,
    output logic [15:0] io_wdata,
    output logic        sw_rd,
    input  logic [15:0] sw_data
);

    localparam int unsigned CW  = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned IOW = 16;
    localparam int unsigned OW  = 10;

    typedef enum logic [2:0] {IDLE, MEM, MEM_WAIT, IO, RESP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            wr_q, wr_n;
    logic            err_q, err_n;

    logic            resp_valid_n, resp_err_n, mem_en_n, mem_we_n;
    logic            led_we_n, seg_we_n, sw_rd_n;
    logic [DW-1:0]   resp_rdata_n, mem_addr_n, mem_wdata_n;
    logic [IOW-1:0]  io_wdata_n;

    // Address decode of the request currently offered
    logic            is_io, misaligned, off_led, off_sw, off_seg, io_hit;
    logic [OW-1:0]   io_off;

    assign is_io      = (req_addr >= IO_BASE);
    assign misaligned = (req_addr[1:0] != 2'b00);
    assign io_off     = OW'(req_addr - IO_BASE);
    assign off_led    = (io_off == LED_OFF);
    assign off_sw     = (io_off == SW_OFF);
    assign off_seg    = (io_off == SEG_OFF);
    assign io_hit     = off_led || off_sw || off_seg;

    assign req_ready  = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            led_we     <= 1'b0;
            seg_we     <= 1'b0;
            sw_rd      <= 1'b0;
            io_wdata   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wr_q       <= wr_n;
            err_q      <= err_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            led_we     <= led_we_n;
            seg_we     <= seg_we_n;
            sw_rd      <= sw_rd_n;
            io_wdata   <= io_wdata_n;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        wr_n         = wr_q;
        err_n        = err_q;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        led_we_n     = 1'b0;
        seg_we_n     = 1'b0;
        sw_rd_n      = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        io_wdata_n   = io_wdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_n  = req_addr;
                    mem_wdata_n = req_wdata;
                    io_wdata_n  = req_wdata[IOW-1:0];
                    wr_n        = req_write;
                    err_n       = 1'b0;
                    if (misaligned || (is_io && !io_hit)) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (!is_io) begin
                        state_n  = MEM;
                        mem_en_n = 1'b1;
                        mem_we_n = req_write;
                    end else begin
                        // Wrong-direction device accesses still take the IO slot, without a strobe
                        state_n  = IO;
                        led_we_n = req_write && off_led;
                        seg_we_n = req_write && off_seg;
                        sw_rd_n  = !req_write && off_sw;
                        err_n    = req_write ? off_sw : !off_sw;
                    end
                end
            end
            MEM: begin
                if (wr_q) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                end else begin
                    state_n = MEM_WAIT;
                    cnt_n   = CW'(MEM_LAT - 1);
                end
            end
            MEM_WAIT: begin
                if (cnt == '0) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = mem_rdata;
                end else begin
                    cnt_n = CW'(cnt - 1'b1);
                end
            end
            IO: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_err_n   = err_q;
                if (sw_rd) begin
                    resp_rdata_n = DW'(sw_data);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
